piso_serializer: RTL

- Parallel-in, serial-out transmitter: the sending end of the team's LSB-first serial link.
- It accepts an n-bit word over a valid/ready handshake and shifts it out one bit per enabled clock, LSB first.
- Frame markers let the downstream deserializer (`shift_reg`, same n) be sampled exactly when the word is complete.
- Sits between the LFSR/word sources and any serial sink; supports back-to-back words with no idle gap.

---
 rtl/piso_serializer_pkg.sv | 13 +
 rtl/piso_serializer_bit_counter.sv | 40 ++++
 rtl/piso_serializer.sv | 90 +++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the LSB-first serial transmitter: FSM encoding and counter sizing.
package piso_serializer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Modulo-MOD bit index counter: clear has priority, saturates at MOD-1 and never wraps.
// tc_o is combinational from the count; the count updates one cycle after clr_i/en_i.
module bit_counter
   import piso_serializer_pkg::*;
#(
   parameter int MOD = 8,
   parameter int W   = cnt_width(MOD)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !tc_o)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, LSB first, one bit per s_en edge; first bit 1 cycle after handshake.
// p_ready only in IDLE or on the enabled last bit (back-to-back); s_en=0 freezes the frame.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int   n          = 8,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [n-1:0] p_data,
   input  logic         p_valid,
   output logic         p_ready,
   input  logic         s_en,
   output logic         s_out,
   output logic         s_valid,
   output logic         s_first,
   output logic         s_last
);

   localparam int CW = cnt_width(n);

   state_e         state_q;
   logic [n-1:0]   sr_q;
   logic [n-1:0]   sr_d;
   logic           s_out_q;
   logic           s_valid_q;
   logic           s_first_q;
   logic           s_last_q;
   logic [CW-1:0]  cnt;
   logic           tc;
   logic           load;
   logic           adv;

   assign p_ready = reset & ((state_q == ST_IDLE) | ((state_q == ST_SHIFT) & tc & s_en));
   assign load    = p_valid & p_ready;
   assign adv     = (state_q == ST_SHIFT) & s_en;

   // Rotate rather than zero-fill: bits past the word are never shown, and every bit stays live.
   assign sr_d = {sr_q[0], sr_q[n-1:1]};

   bit_counter #(
      .MOD (n),
      .W   (CW)
   ) u_bit_counter (
      .clk   (clk),
      .reset (reset),
      .clr_i (load | (adv & tc)),
      .en_i  (adv),
      .cnt_o (cnt),
      .tc_o  (tc)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         sr_q      <= '0;
         s_out_q   <= IDLE_LEVEL;
         s_valid_q <= 1'b0;
         s_first_q <= 1'b0;
         s_last_q  <= 1'b0;
      end else if (load) begin
         state_q   <= ST_SHIFT;
         sr_q      <= p_data;
         s_out_q   <= p_data[0];
         s_valid_q <= 1'b1;
         s_first_q <= 1'b1;
         s_last_q  <= 1'b0;
      end else if (adv) begin
         if (tc) begin
            state_q   <= ST_IDLE;
            s_out_q   <= IDLE_LEVEL;
            s_valid_q <= 1'b0;
            s_first_q <= 1'b0;
            s_last_q  <= 1'b0;
         end else begin
            sr_q      <= sr_d;
            s_out_q   <= sr_q[1];
            s_first_q <= 1'b0;
            s_last_q  <= (cnt == CW'(n - 2));
         end
      end
   end

   assign s_out   = s_out_q;
   assign s_valid = s_valid_q;
   assign s_first = s_first_q;
   assign s_last  = s_last_q;

endmodule
